mem_sdp_ctrl: RTL and testbench
===============================

# mem_sdp_ctrl

Parametrised simple-dual-port synchronous RAM: one write port, one read port, single clock. It generalises the team's 1024x8 memory with configurable width and depth, per-byte write enables, and a selectable read latency and read-during-write policy. It also adds a hardware clear sequencer that zero-fills the array after reset or on request. It sits between datapath producers and consumers as the common on-chip buffer.

## Interface
Parameters:
- `DATA_W`, default 8: data width in bits; must be a multiple of 8.
- `ADDR_W`, default 10: address width; depth `DEPTH = 2**ADDR_W`.
- `READ_LAT`, default 1: read latency, 1 or 2 clock edges.
- `WRITE_FIRST`, default 0: read-during-write policy. 0 returns old data; 1 returns new data.
- `CLR_VAL`, default 0: `DATA_W`-bit fill value used by the clear sequencer.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `w_en`  in  1  write request.
- `write`  in  ADDR_W  write address.
- `w_data`  in  DATA_W  write data.
- `w_be`  in  DATA_W/8  byte enables; bit i covers `w_data[8i+7:8i]`.
- `r_en`  in  1  read request.
- `read`  in  ADDR_W  read address.
- `read_o`  out  DATA_W  read data.
- `r_valid`  out  1  one-cycle pulse; `read_o` holds fresh data.
- `clr`  in  1  clear request; sampled only in IDLE.
- `busy`  out  1  clear sweep in progress; all requests are ignored while high.

## Operation
- FSM states: CLEAR, IDLE.
- While `rst` is high: state=CLEAR, clear counter=0, `read_o`=0, `r_valid`=0, `busy`=1, and all pipeline stages are invalid. Array contents are not reset directly.
- CLEAR: each edge writes `CLR_VAL` to address `cnt` and increments `cnt`. On the edge that writes `DEPTH-1`, the FSM moves to IDLE and `busy` goes to 0. `w_en`, `r_en` and `clr` are ignored. Reads already in flight still complete. Reads issued during CLEAR are dropped and produce no `r_valid`.
- IDLE: `clr`=1 moves the FSM to CLEAR with `cnt`=0. Any `w_en`/`r_en` on that same edge is still serviced.
- Write: with `w_en`=1 in IDLE, each byte lane whose `w_be` bit is set is updated at `write`. Lanes with a clear bit are untouched. `w_be`=0 means no change.
- Read: `r_en`=1 in IDLE launches a read of `read`. Back-to-back reads are allowed every cycle at full throughput.
- Read-during-write with `read`==`write`, both enabled on the same edge:
  - `WRITE_FIRST`=0: return the pre-write word.
  - `WRITE_FIRST`=1: return the merged word, i.e. new bytes where `w_be` is set and old bytes elsewhere.
- Different addresses never interact.
- `read_o` holds its last value when no read completes. It changes only together with `r_valid`=1.
- Reset asserted mid-sweep or mid-read: the sweep restarts from address 0 after release, and in-flight reads are discarded with no `r_valid`.

## Timing
- `busy` stays high during reset and for exactly `DEPTH` rising edges after `rst` deasserts. The first access is accepted on edge `DEPTH+1`.
- `READ_LAT`=1: request sampled at edge N gives `read_o`/`r_valid` updated at edge N, visible during cycle N..N+1.
- `READ_LAT`=2: the same request gives its output at edge N+1 through an additional output register.
- A write at edge N is visible to a read sampled at edge N+1 regardless of `WRITE_FIRST`.
- `r_valid` is high for one cycle per accepted read, in request order.

## Test plan
- Reset/clear (ADDR_W=4, CLR_VAL=8'hA5): release `rst`, then count edges. Required: `busy` high for exactly 16 edges. Reading addresses 0..15 then returns 8'hA5 each, with `r_valid` pulses one cycle after each request (READ_LAT=1).
- Basic write/read (DATA_W=8): write 8'h3C to 56, then read 56 on the next edge. Required: `read_o`=8'h3C and `r_valid`=1 one edge later. With READ_LAT=2, the result arrives two edges later.
- Byte enables (DATA_W=32): write 32'h11223344 with `w_be`=4'hF, then 32'hAABBCCDD with `w_be`=4'b0101 to the same address. Required: readback is 32'h11BB33DD.
- Read-during-write: address 57 holds 8'h10; write 8'h20 to 57 and read 57 on the same edge. Required: `read_o`=8'h10 when WRITE_FIRST=0, 8'h20 when WRITE_FIRST=1. The following read returns 8'h20 in both modes.
- Clear request and ignore: assert `clr` in IDLE, then drive `w_en`=1 to address 3 and `r_en`=1 during `busy`. Required: no `r_valid`, and address 3 reads CLR_VAL after the sweep.
- Reset mid-sweep: pulse `rst` for 1 cycle at sweep count 7. Required: `busy` then stays high for a full `DEPTH` edges from the new release, and `read_o`=0 immediately on reset.

Source files
------------

// File: rtl/mem_sdp_ctrl.sv
// Simple-dual-port synchronous RAM: one write port and one read port on a single
// clock. It has per-byte write enables, a read latency of 1 or 2, a selectable
// read-during-write policy, and a clear sequencer that fills the array after
// reset or on request.
module mem_sdp_ctrl #(
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       ADDR_W      = 10,
    parameter int unsigned       READ_LAT    = 1,
    parameter int unsigned       WRITE_FIRST = 0,
    parameter logic [DATA_W-1:0] CLR_VAL     = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                w_en,
    input  logic [ADDR_W-1:0]   write,
    input  logic [DATA_W-1:0]   w_data,
    input  logic [DATA_W/8-1:0] w_be,
    input  logic                r_en,
    input  logic [ADDR_W-1:0]   read,
    output logic [DATA_W-1:0]   read_o,
    output logic                r_valid,
    input  logic                clr,
    output logic                busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    typedef enum logic [0:0] {StClear, StIdle} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                idle;
    logic                rd_acc;
    logic [DATA_W-1:0]   rd_word;
    logic                s1_valid_q;
    logic [DATA_W-1:0]   s1_data_q;
    logic [DATA_W-1:0]   mem [DEPTH];

    assign idle   = (state_q == StIdle);
    assign busy   = ~idle;
    assign rd_acc = r_en & idle;

    // State and sweep counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StClear;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: sweep every address once, then accept traffic until a clear request
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StClear: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (clr) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StClear;
                cnt_d   = '0;
            end
        endcase
    end

    // Array write: clear fill during the sweep, byte-lane writes when idle
    always_ff @(posedge clk) begin
        if (!idle) begin
            mem[cnt_q] <= CLR_VAL;
        end else if (w_en) begin
            for (int i = 0; i < NB; i++) begin
                if (w_be[i]) begin
                    mem[write][8*i +: 8] <= w_data[8*i +: 8];
                end
            end
        end
    end

    // Read word: old contents, or merged with same-edge write lanes in write-first mode
    always_comb begin
        rd_word = mem[read];
        if ((WRITE_FIRST != 0) && w_en && idle && (write == read)) begin
            for (int i = 0; i < NB; i++) begin
                if (w_be[i]) begin
                    rd_word[8*i +: 8] = w_data[8*i +: 8];
                end
            end
        end
    end

    // First read stage: data only moves when a read is accepted so the output holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= rd_acc;
            if (rd_acc) begin
                s1_data_q <= rd_word;
            end
        end
    end

    if (READ_LAT == 2) begin : g_lat2
        logic              s2_valid_q;
        logic [DATA_W-1:0] s2_data_q;

        // Extra output register; in-flight reads finish even if a sweep has started
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s2_valid_q <= 1'b0;
                s2_data_q  <= '0;
            end else begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_q <= s1_data_q;
                end
            end
        end

        assign read_o  = s2_data_q;
        assign r_valid = s2_valid_q;
    end else begin : g_lat1
        assign read_o  = s1_data_q;
        assign r_valid = s1_valid_q;
    end

endmodule

// File: tb/tb_mem_sdp_ctrl.sv
// Bench for mem_sdp_ctrl. Three instances share one stimulus stream:
//   u_c: 16x8, fill 8'hA5, latency 1, read-first
//   u_w: 64x32, fill 0, latency 1, read-first
//   u_n: 64x16, fill 0, latency 2, write-first
module tb_mem_sdp_ctrl;

    logic        clk;
    logic        rst;
    logic        w_en;
    logic        r_en;
    logic        clr;
    logic [5:0]  wa;
    logic [5:0]  ra;
    logic [31:0] wd;
    logic [3:0]  be;

    logic [7:0]  q_c;
    logic [31:0] q_w;
    logic [15:0] q_n;
    logic        v_c, v_w, v_n;
    logic        busy_c, busy_w, busy_n;

    int checks;
    int errors;

    typedef struct packed {
        logic        w_en;
        logic [5:0]  wa;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        r_en;
        logic [5:0]  ra;
        logic        w_vld;
        logic [31:0] w_q;
        logic        n_vld;
        logic [15:0] n_q;
    } vec_t;

    vec_t vecs [17];

    mem_sdp_ctrl #(
        .DATA_W(8), .ADDR_W(4), .READ_LAT(1), .WRITE_FIRST(0), .CLR_VAL(8'hA5)
    ) u_c (
        .clk(clk), .rst(rst), .w_en(w_en), .write(wa[3:0]), .w_data(wd[7:0]),
        .w_be(be[0:0]), .r_en(r_en), .read(ra[3:0]), .read_o(q_c), .r_valid(v_c),
        .clr(clr), .busy(busy_c)
    );

    mem_sdp_ctrl #(
        .DATA_W(32), .ADDR_W(6), .READ_LAT(1), .WRITE_FIRST(0), .CLR_VAL(32'h0)
    ) u_w (
        .clk(clk), .rst(rst), .w_en(w_en), .write(wa), .w_data(wd),
        .w_be(be), .r_en(r_en), .read(ra), .read_o(q_w), .r_valid(v_w),
        .clr(clr), .busy(busy_w)
    );

    mem_sdp_ctrl #(
        .DATA_W(16), .ADDR_W(6), .READ_LAT(2), .WRITE_FIRST(1), .CLR_VAL(16'h0)
    ) u_n (
        .clk(clk), .rst(rst), .w_en(w_en), .write(wa), .w_data(wd[15:0]),
        .w_be(be[1:0]), .r_en(r_en), .read(ra), .read_o(q_n), .r_valid(v_n),
        .clr(clr), .busy(busy_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [5:0] a, input logic [31:0] d,
                                input logic [3:0] b, input logic re, input logic [5:0] r,
                                input logic wv, input logic [31:0] wq,
                                input logic nv, input logic [15:0] nq);
        vec_t v;
        v.w_en = we; v.wa = a; v.wd = d; v.be = b; v.r_en = re; v.ra = r;
        v.w_vld = wv; v.w_q = wq; v.n_vld = nv; v.n_q = nq;
        return v;
    endfunction

    // Edges until each instance drops busy; 0 means it never did within the bound
    task automatic count_busy(output int c_n, output int w_n, output int n_n);
        c_n = 0; w_n = 0; n_n = 0;
        for (int i = 1; i <= 200; i++) begin
            step();
            if (!busy_c && c_n == 0) c_n = i;
            if (!busy_w && w_n == 0) w_n = i;
            if (!busy_n && n_n == 0) n_n = i;
        end
    endtask

    initial begin
        int c_n, w_n, n_n;
        int waited;

        checks = 0;
        errors = 0;

        // Expected outputs are those seen just after each vector's edge.
        vecs[0]  = mk(1, 56, 32'h0000003C, 4'hF,    0, 0,  0, 32'h0000003C & 32'h0, 0, 16'h0000);
        vecs[1]  = mk(0, 0,  32'h0,        4'h0,    1, 56, 1, 32'h0000003C, 0, 16'h0000);
        vecs[2]  = mk(0, 0,  32'h0,        4'h0,    0, 0,  0, 32'h0000003C, 1, 16'h003C);
        vecs[3]  = mk(1, 20, 32'h11223344, 4'hF,    0, 0,  0, 32'h0000003C, 0, 16'h003C);
        vecs[4]  = mk(1, 20, 32'hAABBCCDD, 4'b0101, 0, 0,  0, 32'h0000003C, 0, 16'h003C);
        vecs[5]  = mk(0, 0,  32'h0,        4'h0,    1, 20, 1, 32'h11BB33DD, 0, 16'h003C);
        vecs[6]  = mk(1, 20, 32'hFFFFFFFF, 4'h0,    1, 20, 1, 32'h11BB33DD, 1, 16'h33DD);
        vecs[7]  = mk(0, 0,  32'h0,        4'h0,    0, 0,  0, 32'h11BB33DD, 1, 16'h33DD);
        vecs[8]  = mk(1, 57, 32'h00000010, 4'hF,    0, 0,  0, 32'h11BB33DD, 0, 16'h33DD);
        vecs[9]  = mk(1, 57, 32'h00000020, 4'hF,    1, 57, 1, 32'h00000010, 0, 16'h33DD);
        vecs[10] = mk(0, 0,  32'h0,        4'h0,    1, 57, 1, 32'h00000020, 1, 16'h0020);
        vecs[11] = mk(0, 0,  32'h0,        4'h0,    0, 0,  0, 32'h00000020, 1, 16'h0020);
        vecs[12] = mk(1, 20, 32'h0000EE99, 4'b0010, 1, 20, 1, 32'h11BB33DD, 0, 16'h0020);
        vecs[13] = mk(0, 0,  32'h0,        4'h0,    1, 20, 1, 32'h11BBEEDD, 1, 16'hEEDD);
        vecs[14] = mk(0, 0,  32'h0,        4'h0,    0, 0,  0, 32'h11BBEEDD, 1, 16'hEEDD);
        vecs[15] = mk(1, 3,  32'h12345678, 4'hF,    0, 0,  0, 32'h11BBEEDD, 0, 16'hEEDD);
        vecs[16] = mk(0, 0,  32'h0,        4'h0,    0, 0,  0, 32'h11BBEEDD, 0, 16'hEEDD);

        rst = 1'b1; w_en = 1'b0; r_en = 1'b0; clr = 1'b0;
        wa = '0; ra = '0; wd = '0; be = '0;

        // Reset state
        repeat (3) step();
        check("rst busy_c", {31'b0, busy_c}, 32'd1);
        check("rst busy_w", {31'b0, busy_w}, 32'd1);
        check("rst busy_n", {31'b0, busy_n}, 32'd1);
        check("rst r_valid_c", {31'b0, v_c}, 32'd0);
        check("rst r_valid_n", {31'b0, v_n}, 32'd0);
        check("rst read_o_c", {24'b0, q_c}, 32'd0);
        check("rst read_o_w", q_w, 32'd0);
        check("rst read_o_n", {16'b0, q_n}, 32'd0);

        // Initial sweep length
        rst = 1'b0;
        count_busy(c_n, w_n, n_n);
        check("sweep edges c", c_n, 32'd16);
        check("sweep edges w", w_n, 32'd64);
        check("sweep edges n", n_n, 32'd64);

        // Back-to-back readback of the filled small array
        for (int a = 0; a < 16; a++) begin
            r_en = 1'b1;
            ra   = 6'(a);
            step();
            check($sformatf("fill r_valid_c[%0d]", a), {31'b0, v_c}, 32'd1);
            check($sformatf("fill read_o_c[%0d]", a), {24'b0, q_c}, 32'h000000A5);
            check($sformatf("fill read_o_w[%0d]", a), q_w, 32'h0);
        end
        r_en = 1'b0;
        step();
        check("idle r_valid_c", {31'b0, v_c}, 32'd0);
        check("hold read_o_c", {24'b0, q_c}, 32'h000000A5);

        // Table: write/read, byte enables, read-during-write in both policies
        for (int i = 0; i < 17; i++) begin
            w_en = vecs[i].w_en; wa = vecs[i].wa; wd = vecs[i].wd; be = vecs[i].be;
            r_en = vecs[i].r_en; ra = vecs[i].ra;
            step();
            check($sformatf("vec%0d r_valid_w", i), {31'b0, v_w}, {31'b0, vecs[i].w_vld});
            check($sformatf("vec%0d read_o_w", i), q_w, vecs[i].w_q);
            check($sformatf("vec%0d r_valid_n", i), {31'b0, v_n}, {31'b0, vecs[i].n_vld});
            check($sformatf("vec%0d read_o_n", i), {16'b0, q_n}, {16'b0, vecs[i].n_q});
        end
        w_en = 1'b0; r_en = 1'b0; wa = '0; ra = '0; wd = '0; be = '0;

        // Clear request; traffic during the sweep is ignored
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr busy_c", {31'b0, busy_c}, 32'd1);
        check("clr busy_w", {31'b0, busy_w}, 32'd1);
        check("clr busy_n", {31'b0, busy_n}, 32'd1);
        w_en = 1'b1; wa = 6'd3; wd = 32'hDEADBEEF; be = 4'hF;
        r_en = 1'b1; ra = 6'd3;
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("busy r_valid_c[%0d]", k), {31'b0, v_c}, 32'd0);
            check($sformatf("busy r_valid_w[%0d]", k), {31'b0, v_w}, 32'd0);
            check($sformatf("busy r_valid_n[%0d]", k), {31'b0, v_n}, 32'd0);
        end
        w_en = 1'b0; r_en = 1'b0; be = '0;
        waited = 0;
        while ((busy_c || busy_w || busy_n) && waited < 200) begin
            step();
            waited++;
        end
        check("clear completes", {29'b0, busy_c, busy_w, busy_n}, 32'd0);

        r_en = 1'b1; ra = 6'd3;
        step();
        r_en = 1'b0;
        check("cleared r_valid_c", {31'b0, v_c}, 32'd1);
        check("cleared read_o_c", {24'b0, q_c}, 32'h000000A5);
        check("cleared r_valid_w", {31'b0, v_w}, 32'd1);
        check("cleared read_o_w", q_w, 32'h0);
        step();
        check("cleared r_valid_n", {31'b0, v_n}, 32'd1);
        check("cleared read_o_n", {16'b0, q_n}, 32'h0);

        // Read issued with clr is serviced; the two-stage read completes inside the sweep
        r_en = 1'b1; ra = 6'd3; clr = 1'b1;
        step();
        r_en = 1'b0; clr = 1'b0;
        check("clr-edge r_valid_w", {31'b0, v_w}, 32'd1);
        check("clr-edge r_valid_n", {31'b0, v_n}, 32'd0);
        step();
        check("inflight r_valid_n", {31'b0, v_n}, 32'd1);
        check("inflight busy_n", {31'b0, busy_n}, 32'd1);
        repeat (6) step();

        // Reset mid-sweep at count 7
        rst = 1'b1;
        #1;
        check("midrst read_o_c", {24'b0, q_c}, 32'd0);
        check("midrst r_valid_w", {31'b0, v_w}, 32'd0);
        check("midrst busy_c", {31'b0, busy_c}, 32'd1);
        step();
        rst = 1'b0;
        count_busy(c_n, w_n, n_n);
        check("resweep edges c", c_n, 32'd16);
        check("resweep edges w", w_n, 32'd64);
        check("resweep edges n", n_n, 32'd64);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
